// File: rtl/irq_vector_arbiter.sv
// irq_vector_arbiter: interrupt front-end for the RV32I core.
// Latches rising edges of the raw interrupt lines as pending, picks the
// lowest-index enabled source, and hands one request at a time to the core
// controller over a req/grant handshake, holding off further requests until
// the handler reports completion. No nesting.
//
// Handshake: irq_req_o is raised from IDLE together with a frozen irq_id_o /
// irq_addr_o and stays up, unchanged, until irq_grant_i is sampled high on a
// rising edge; that edge drops irq_req_o, raises in_service_o and retires the
// pending bit. irq_done_i sampled high while in service returns the block to
// IDLE. A grant without an outstanding request, or a done without a handler
// in service, has no effect. clear_i overrides everything.
module irq_vector_arbiter #(
  parameter int unsigned N_SRC      = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int unsigned ID_W       = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             global_en_i,
  input  logic             clear_i,
  input  logic             irq_grant_i,
  input  logic             irq_done_i,
  output logic             irq_req_o,
  output logic [31:0]      irq_addr_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic             in_service_o,
  output logic [N_SRC-1:0] pending_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  state_e           state_q;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] edge_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] eligible;
  logic             any_eligible;
  logic [ID_W-1:0]  win_id;
  logic [31:0]      win_addr;
  logic             req_q;
  logic [31:0]      addr_q;
  logic [ID_W-1:0]  id_q;
  logic             in_service_q;

  assign edge_vec     = irq_src_i & ~src_q;
  assign eligible     = global_en_i ? (pending_q & irq_mask_i) : '0;
  assign any_eligible = |eligible;
  assign win_addr     = VEC_BASE + (32'(win_id) * VEC_STRIDE);

  // Fixed priority: scan from the top so the lowest set index is left last.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  // Retire the pending bit of the request being granted this cycle.
  always_comb begin
    clr_vec = '0;
    if ((state_q == S_REQ) && irq_grant_i) clr_vec = N_SRC'(1) << id_q;
  end

  // Next pending: a new edge beats a same-cycle retire; a flush beats both.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | edge_vec;
    if (clear_i) pending_d = '0;
  end

  // Edge-detect history and pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pending_q <= '0;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= pending_d;
    end
  end

  // Request/service sequencer with registered request, vector and id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      id_q         <= '0;
      in_service_q <= 1'b0;
    end else if (clear_i) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_eligible) begin
            id_q    <= win_id;
            addr_q  <= win_addr;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (irq_grant_i) begin
            req_q        <= 1'b0;
            in_service_q <= 1'b1;
            state_q      <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (irq_done_i) begin
            in_service_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_q        <= 1'b0;
          addr_q       <= '0;
          id_q         <= '0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o    = req_q;
  assign irq_addr_o   = addr_q;
  assign irq_id_o     = id_q;
  assign in_service_o = in_service_q;
  assign pending_o    = pending_q;

endmodule

// File: tb/tb_irq_vector_arbiter.sv
// Bench for irq_vector_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level reference model and a request queue.
module tb_irq_vector_arbiter;

  localparam int N    = 8;
  localparam int ID_W = 3;
  localparam int W    = 32 + ID_W;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    irq_src_i;
  logic [N-1:0]    irq_mask_i;
  logic            global_en_i;
  logic            clear_i;
  logic            irq_grant_i;
  logic            irq_done_i;
  logic            irq_req_o;
  logic [31:0]     irq_addr_o;
  logic [ID_W-1:0] irq_id_o;
  logic            in_service_o;
  logic [N-1:0]    pending_o;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  irq_vector_arbiter #(
    .N_SRC(N), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(4), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_src_i(irq_src_i), .irq_mask_i(irq_mask_i),
    .global_en_i(global_en_i), .clear_i(clear_i), .irq_grant_i(irq_grant_i),
    .irq_done_i(irq_done_i), .irq_req_o(irq_req_o), .irq_addr_o(irq_addr_o),
    .irq_id_o(irq_id_o), .in_service_o(in_service_o), .pending_o(pending_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase: 0 = idle, 1 = request outstanding, 2 = handler running.
  bit m_pend[N];
  bit m_prev[N];
  bit m_edge[N];
  int m_phase;
  int m_id;
  int m_win;

  function automatic logic [31:0] vec_addr(input int id);
    return 32'(256 + id * 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_phase = 0;
      m_id    = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_edge[i] = irq_src_i[i] && !m_prev[i];
        m_prev[i] = irq_src_i[i];
      end
      if (clear_i) begin
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_phase = 0;
      end else begin
        if (m_phase == 0) begin
          m_win = -1;
          if (global_en_i)
            for (int i = 0; i < N; i++)
              if (m_win < 0 && m_pend[i] && irq_mask_i[i]) m_win = i;
          if (m_win >= 0) begin
            m_id    = m_win;
            m_phase = 1;
            exp_q.push_back({vec_addr(m_win), ID_W'(m_win)});
          end
        end else if (m_phase == 1) begin
          if (irq_grant_i) begin
            m_pend[m_id] = 1'b0;
            m_phase      = 2;
          end
        end else begin
          if (irq_done_i) m_phase = 0;
        end
        for (int i = 0; i < N; i++) if (m_edge[i]) m_pend[i] = 1'b1;
      end
    end
  end

  function automatic logic [N-1:0] model_pend();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit   mon_en   = 1'b0;
  logic prev_req = 1'b0;
  logic [W-1:0] exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else if (mon_en) begin
      chk("mon_pending", 64'(pending_o), 64'(model_pend()));
      chk("mon_req", 64'(irq_req_o), 64'(m_phase == 1));
      chk("mon_in_service", 64'(in_service_o), 64'(m_phase == 2));
      if (m_phase != 0) chk("mon_id", 64'(irq_id_o), 64'(m_id));
      if (irq_req_o && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_req", 64'(irq_req_o), 64'(0));
        end else begin
          exp_v = exp_q.pop_front();
          chk("sb_req_addr", 64'(irq_addr_o), 64'(exp_v[W-1:ID_W]));
          chk("sb_req_id", 64'(irq_id_o), 64'(exp_v[ID_W-1:0]));
        end
      end
      prev_req = irq_req_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_src(input logic [N-1:0] v);
    irq_src_i = v;
    cyc(1);
    irq_src_i = '0;
  endtask

  task automatic grant_cycle();
    irq_grant_i = 1'b1;
    cyc(1);
    irq_grant_i = 1'b0;
  endtask

  task automatic done_cycle();
    irq_done_i = 1'b1;
    cyc(1);
    irq_done_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] src_r;

  initial begin
    rst_n = 1'b1; irq_src_i = '0; irq_mask_i = '0; global_en_i = 1'b0;
    clear_i = 1'b0; irq_grant_i = 1'b0; irq_done_i = 1'b0;
    #2 rst_n = 1'b0;
    cyc(2);
    chk("rst_req", 64'(irq_req_o), 64'(0));
    chk("rst_addr", 64'(irq_addr_o), 64'(0));
    chk("rst_id", 64'(irq_id_o), 64'(0));
    chk("rst_in_service", 64'(in_service_o), 64'(0));
    chk("rst_pending", 64'(pending_o), 64'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc(1);

    // Single source.
    irq_mask_i = 8'hFF; global_en_i = 1'b1;
    pulse_src(8'h08);
    chk("t1_pending", 64'(pending_o), 64'h08);
    chk("t1_no_req_yet", 64'(irq_req_o), 64'(0));
    cyc(1);
    chk("t1_req", 64'(irq_req_o), 64'(1));
    chk("t1_addr", 64'(irq_addr_o), 64'h10C);
    chk("t1_id", 64'(irq_id_o), 64'(3));
    grant_cycle();
    chk("t1_pending_cleared", 64'(pending_o), 64'(0));
    chk("t1_in_service", 64'(in_service_o), 64'(1));
    chk("t1_req_dropped", 64'(irq_req_o), 64'(0));
    done_cycle();
    chk("t1_idle", 64'(in_service_o), 64'(0));

    // Priority and lock.
    pulse_src(8'h24);
    cyc(1);
    chk("t2_id2", 64'(irq_id_o), 64'(2));
    chk("t2_addr2", 64'(irq_addr_o), 64'h108);
    pulse_src(8'h01);
    chk("t2_locked_id", 64'(irq_id_o), 64'(2));
    chk("t2_locked_req", 64'(irq_req_o), 64'(1));
    grant_cycle();
    done_cycle();
    chk("t2_idle_gap", 64'(irq_req_o), 64'(0));
    cyc(1);
    chk("t2_id0", 64'(irq_id_o), 64'(0));
    chk("t2_addr0", 64'(irq_addr_o), 64'h100);
    grant_cycle();
    done_cycle();
    cyc(1);
    chk("t2_id5", 64'(irq_id_o), 64'(5));
    chk("t2_addr5", 64'(irq_addr_o), 64'h114);
    grant_cycle();
    done_cycle();

    // Masking.
    irq_mask_i = 8'hFD;
    pulse_src(8'h02);
    chk("t3_pending_masked", 64'(pending_o), 64'h02);
    cyc(2);
    chk("t3_no_req", 64'(irq_req_o), 64'(0));
    irq_mask_i = 8'hFF;
    cyc(1);
    chk("t3_req_unmasked", 64'(irq_req_o), 64'(1));
    chk("t3_id1", 64'(irq_id_o), 64'(1));
    grant_cycle();
    done_cycle();

    // Set/clear collision on source 4.
    pulse_src(8'h10);
    cyc(1);
    chk("t4_id4", 64'(irq_id_o), 64'(4));
    irq_src_i = 8'h10;
    grant_cycle();
    irq_src_i = '0;
    chk("t4_pending_kept", 64'(pending_o), 64'h10);
    chk("t4_in_service", 64'(in_service_o), 64'(1));
    done_cycle();
    cyc(1);
    chk("t4_second_req", 64'(irq_req_o), 64'(1));
    chk("t4_second_id", 64'(irq_id_o), 64'(4));
    grant_cycle();
    done_cycle();

    // Flush in REQ with three bits pending.
    pulse_src(8'h0E);
    cyc(1);
    chk("t5_req_before_clear", 64'(irq_req_o), 64'(1));
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    chk("t5_clear_req", 64'(irq_req_o), 64'(0));
    chk("t5_clear_pending", 64'(pending_o), 64'(0));

    // Asynchronous reset mid-service.
    pulse_src(8'h40);
    cyc(1);
    grant_cycle();
    chk("t5_in_service", 64'(in_service_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_in_service", 64'(in_service_o), 64'(0));
    chk("t5_async_req", 64'(irq_req_o), 64'(0));
    chk("t5_async_id", 64'(irq_id_o), 64'(0));
    chk("t5_async_addr", 64'(irq_addr_o), 64'(0));
    chk("t5_async_pending", 64'(pending_o), 64'(0));
    cyc(1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Spurious handshakes.
    grant_cycle();
    chk("t6_grant_idle_req", 64'(irq_req_o), 64'(0));
    chk("t6_grant_idle_svc", 64'(in_service_o), 64'(0));
    pulse_src(8'h80);
    cyc(1);
    done_cycle();
    chk("t6_done_req_held", 64'(irq_req_o), 64'(1));
    chk("t6_done_req_id", 64'(irq_id_o), 64'(7));
    chk("t6_done_req_addr", 64'(irq_addr_o), 64'h11C);
    grant_cycle();
    done_cycle();

    // Random traffic against the reference model.
    src_r = '0;
    for (int n = 0; n < 2000; n++) begin
      src_r ^= N'($urandom & $urandom & $urandom);
      irq_src_i = src_r;
      if ($urandom_range(0, 15) == 0) irq_mask_i = N'($urandom);
      else if ($urandom_range(0, 7) == 0) irq_mask_i = 8'hFF;
      global_en_i = ($urandom_range(0, 9) != 0);
      clear_i     = ($urandom_range(0, 63) == 0);
      irq_grant_i = ($urandom_range(0, 2) == 0);
      irq_done_i  = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    irq_src_i = '0; clear_i = 1'b0; irq_grant_i = 1'b0; irq_done_i = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    chk("sb_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_vector_arbiter.md
# irq_vector_arbiter

Interrupt front-end for the RV32I core. Collects up to `N_SRC` external interrupt lines, latches rising edges as pending, and selects the highest-priority enabled source. It then presents a single request and handler vector to the core controller FSM over a req/grant handshake, and blocks further requests until the handler signals completion. Only one interrupt is in service at a time; nesting is not supported.

## Interface
Parameters:
- `N_SRC`, 8: number of interrupt sources, 2..32.
- `VEC_BASE`, 32'h0000_0100: handler address of source 0.
- `VEC_STRIDE`, 4: byte distance between consecutive handler vectors.
- `ID_W`, $clog2(N_SRC): width of the source id.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_src_i`  in  N_SRC  raw interrupt lines; a rising edge marks the source pending.
- `irq_mask_i`  in  N_SRC  per-source enable, 1 = enabled.
- `global_en_i`  in  1  global interrupt enable.
- `clear_i`  in  1  synchronous flush: drops all pending bits and returns to IDLE.
- `irq_grant_i`  in  1  core controller accepts the current request.
- `irq_done_i`  in  1  handler return executed.
- `irq_req_o`  out  1  request to core controller.
- `irq_addr_o`  out  32  handler address; valid while `irq_req_o` = 1.
- `irq_id_o`  out  ID_W  id of requested or in-service source.
- `in_service_o`  out  1  handler is running.
- `pending_o`  out  N_SRC  raw pending register.

## Operation
- Edge detect:
  - `src_q` holds `irq_src_i` registered each cycle.
  - `edge = irq_src_i & ~src_q`.
  - `pending <= (pending & ~clr_vec) | edge`. If set and clear of the same bit fall in the same cycle, set wins.
- Pending bits latch regardless of the mask. Masked bits stay pending and become eligible once unmasked.
- `eligible = pending & irq_mask_i`, gated by `global_en_i`. Priority is fixed; the lowest index wins.
- States:
  - **IDLE**: `req`=0. If eligible ≠ 0, register `id` = winner, `addr = VEC_BASE + id*VEC_STRIDE` (32-bit, wraps mod 2^32), `req`=1, and go to REQ.
  - **REQ**: `req`=1. `id` and `addr` are frozen. A later higher-priority edge, a mask change, or `global_en_i` dropping does not withdraw or change the request. On `irq_grant_i`: clear `pending[id]`, `req`=0, `in_service`=1, go to SERVICE.
  - **SERVICE**: `in_service`=1, `id` holds. On `irq_done_i`: `in_service`=0, go to IDLE.
- A grant outside REQ is ignored. A done outside SERVICE is ignored.
- `clear_i` takes precedence over every transition. Next edge: pending=0, `req`=0, `in_service`=0, state=IDLE. Edges arriving in the same cycle as `clear_i` are discarded.
- Unused encodings return to IDLE with all outputs cleared.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE, `src_q`=0, pending=0, `irq_req_o`=0, `irq_addr_o`=0, `irq_id_o`=0, `in_service_o`=0, `pending_o`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: `irq_src_i` rises before edge k → `pending_o` bit set after k → `irq_req_o`=1 after k+1, provided the source is eligible and the block is IDLE.
- Handshake: a grant sampled with `req`=1 at edge g → `req`=0, `in_service_o`=1 after g. The cleared pending bit is visible after g.
- `irq_done_i` at edge d → IDLE after d. The earliest next `irq_req_o` is after d+1, giving one mandatory IDLE cycle.
- A source held high generates only one pending event. It must fall and rise again to re-pend.
- Reset asserted mid-REQ or mid-SERVICE aborts immediately. No pending state survives.

## Test plan
- Single source: pulse `irq_src_i[3]` with mask=0xFF and `global_en`=1. Expect `pending_o`=0x08 one cycle later, then `irq_req_o`=1 with `irq_addr_o`=0x10C and `irq_id_o`=3. After grant: `pending_o`=0, `in_service_o`=1. After done: back to IDLE.
- Priority and lock: sources 5 and 2 rise together → request for id 2 (addr 0x108). Source 0 rises during REQ → request stays id 2. After done plus one cycle, next request is id 0 (0x100), then id 5 (0x114).
- Masking: source 1 rises with `mask[1]`=0. Expect `pending_o`=0x02 and no request. Set `mask[1]`=1 → `irq_req_o` asserts on the following cycle.
- Set/clear collision: source 4 rises again in the same cycle its grant is sampled. Expect `pending_o[4]`=1 afterward, and a second request for id 4 after done.
- Flush and reset: assert `clear_i` in REQ with 3 bits pending → next cycle `req`=0 and pending=0. Assert `rst_n`=0 mid-SERVICE → all outputs 0 asynchronously.
- Spurious handshakes: grant in IDLE and done in REQ → no state change, and the request stays asserted.
